// File: rtl/tblink_rpc_pkg.sv
// tblink_rpc_pkg
// Shared definitions for the TbLink RPC host endpoint: the state encoding used
// by the top-level controller and the frame serializer, the response command
// code, and a helper that clamps the request parameter count.
// No ports (package).

package tblink_rpc_pkg;

  // One encoding covers the whole request/response cycle. The serializer walks
  // the StTx* values; the top level uses the others.
  typedef enum logic [3:0] {
    StIdle  = 4'd0,
    StTxDst = 4'd1,
    StTxSz  = 4'd2,
    StTxCmd = 4'd3,
    StTxId  = 4'd4,
    StTxDat = 4'd5,
    StRxSz  = 4'd6,
    StRxCmd = 4'd7,
    StRxId  = 4'd8,
    StRxDat = 4'd9,
    StDone  = 4'd10
  } state_e;

  // Command code carried by every well-formed response frame.
  localparam logic [7:0] RspCmd = 8'h00;

  // The on-wire SZ field is sz+1 in 8 bits, so 255 parameter bytes cannot be
  // expressed; such requests are sent with 254.
  function automatic logic [7:0] clamp_sz(input logic [7:0] sz);
    return (sz == 8'hFF) ? 8'hFE : sz;
  endfunction

endpackage

// File: rtl/tblink_rpc_msg_tx.sv
// tblink_rpc_msg_tx
// Request frame serializer. On i_start it captures the command, parameter
// count and parameter bytes, then emits DST_ID, sz+1, cmd, id and the
// parameter bytes over a valid/ready byte stream. Owns the 8-bit frame id.
// Ports:
//   i_clk, i_rst_n      clock, async active-low reset
//   i_start             capture request and begin a frame (only sampled idle)
//   i_cmd, i_sz         command code and parameter byte count
//   i_params            parameter bytes, byte k at [8k+:8]
//   o_dat/o_valid/i_ready  outgoing byte stream
//   o_done              last byte of the frame accepted this cycle
//   o_id                id to be used by the next frame

module tblink_rpc_msg_tx
  import tblink_rpc_pkg::*;
#(
  parameter int unsigned REQ_PARAMS_SZ = 1,
  parameter logic [7:0]  DST_ID        = 8'h00
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_start,
  input  logic [7:0]                 i_cmd,
  input  logic [7:0]                 i_sz,
  input  logic [REQ_PARAMS_SZ*8-1:0] i_params,
  output logic [7:0]                 o_dat,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic                       o_done,
  output logic [7:0]                 o_id
);

  state_e                     r_state;
  state_e                     w_state_nxt;
  logic [7:0]                 r_cmd;
  logic [7:0]                 r_sz;
  logic [REQ_PARAMS_SZ*8-1:0] r_params;
  logic [7:0]                 r_idx;
  logic [7:0]                 r_id;
  logic                       w_fire;
  logic                       w_last_dat;
  logic [7:0]                 w_param_byte;

  assign w_fire     = o_valid & i_ready;
  assign w_last_dat = (r_idx == r_sz - 8'd1);
  assign o_id       = r_id;

  // Indices past the captured parameter storage read as zero.
  always_comb begin
    w_param_byte = 8'h00;
    for (int k = 0; k < int'(REQ_PARAMS_SZ) && k < 256; k++) begin
      if (r_idx == 8'(k)) begin
        w_param_byte = r_params[8*k +: 8];
      end
    end
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:  if (i_start) w_state_nxt = StTxDst;
      StTxDst: if (w_fire) w_state_nxt = StTxSz;
      StTxSz:  if (w_fire) w_state_nxt = StTxCmd;
      StTxCmd: if (w_fire) w_state_nxt = StTxId;
      StTxId:  if (w_fire) w_state_nxt = (r_sz == 8'd0) ? StIdle : StTxDat;
      StTxDat: if (w_fire && w_last_dat) w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  // Outputs: data is decoded from registered state only, so it holds while stalled.
  always_comb begin
    o_valid = 1'b0;
    o_dat   = 8'h00;
    o_done  = 1'b0;
    unique case (r_state)
      StTxDst: begin
        o_valid = 1'b1;
        o_dat   = DST_ID;
      end
      StTxSz: begin
        o_valid = 1'b1;
        o_dat   = r_sz + 8'd1;
      end
      StTxCmd: begin
        o_valid = 1'b1;
        o_dat   = r_cmd;
      end
      StTxId: begin
        o_valid = 1'b1;
        o_dat   = r_id;
        o_done  = i_ready && (r_sz == 8'd0);
      end
      StTxDat: begin
        o_valid = 1'b1;
        o_dat   = w_param_byte;
        o_done  = i_ready && w_last_dat;
      end
      default: ;
    endcase
  end

  // Request capture, parameter index and frame id.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cmd    <= 8'h00;
      r_sz     <= 8'h00;
      r_params <= '0;
      r_idx    <= 8'h00;
      r_id     <= 8'h00;
    end else begin
      if (r_state == StIdle && i_start) begin
        r_cmd    <= i_cmd;
        r_sz     <= clamp_sz(i_sz);
        r_params <= i_params;
        r_idx    <= 8'h00;
      end
      if (r_state == StTxId && w_fire) begin
        r_id <= r_id + 8'd1;
      end
      if (r_state == StTxDat && w_fire) begin
        r_idx <= r_idx + 8'd1;
      end
    end
  end

endmodule

// File: rtl/tblink_rpc_hostep.sv
// tblink_rpc_hostep
// Host-side RPC endpoint. A toggle on req_put_i posts one request; the
// serializer sends it, then this block receives the response frame
// (SZ, CMD, ID, data...), stores up to RSP_SZ data bytes, flags malformed
// responses and toggles req_get_i to signal completion.
// Ports:
//   uclock, reset                  clock, async active-low reset
//   txo_dat/txo_valid/txo_ready    request byte stream out
//   rxi_dat/rxi_valid/rxi_ready    response byte stream in
//   req_cmd, req_sz, req_params    request contents
//   req_put_i / req_get_i          toggle handshake (done when equal)
//   rsp_dat, rsp_sz, rsp_err       response data, data byte count, error flag

module tblink_rpc_hostep
  import tblink_rpc_pkg::*;
#(
  parameter int unsigned REQ_PARAMS_SZ = 1,
  parameter int unsigned RSP_SZ        = 1,
  parameter logic [7:0]  DST_ID        = 8'h00
) (
  input  logic                       uclock,
  input  logic                       reset,
  output logic [7:0]                 txo_dat,
  output logic                       txo_valid,
  input  logic                       txo_ready,
  input  logic [7:0]                 rxi_dat,
  input  logic                       rxi_valid,
  output logic                       rxi_ready,
  input  logic [7:0]                 req_cmd,
  input  logic [7:0]                 req_sz,
  input  logic [REQ_PARAMS_SZ*8-1:0] req_params,
  input  logic                       req_put_i,
  output logic                       req_get_i,
  output logic [RSP_SZ*8-1:0]        rsp_dat,
  output logic [7:0]                 rsp_sz,
  output logic                       rsp_err
);

  state_e              r_state;
  state_e              w_state_nxt;
  logic                r_get;
  logic [RSP_SZ*8-1:0] r_rsp_dat;
  logic [7:0]          r_rsp_sz;
  logic                r_rsp_err;
  logic [7:0]          r_rx_idx;
  logic                w_start;
  logic                w_tx_done;
  logic [7:0]          w_id;
  logic [7:0]          w_id_sent;
  logic                w_rx_fire;

  assign req_get_i = r_get;
  assign rsp_dat   = r_rsp_dat;
  assign rsp_sz    = r_rsp_sz;
  assign rsp_err   = r_rsp_err;
  assign w_rx_fire = rxi_valid & rxi_ready;
  // The serializer bumps its id as soon as the ID byte goes out, so the id of
  // the outstanding frame is one behind.
  assign w_id_sent = w_id - 8'd1;

  tblink_rpc_msg_tx #(
    .REQ_PARAMS_SZ (REQ_PARAMS_SZ),
    .DST_ID        (DST_ID)
  ) u_msg_tx (
    .i_clk    (uclock),
    .i_rst_n  (reset),
    .i_start  (w_start),
    .i_cmd    (req_cmd),
    .i_sz     (req_sz),
    .i_params (req_params),
    .o_dat    (txo_dat),
    .o_valid  (txo_valid),
    .i_ready  (txo_ready),
    .o_done   (w_tx_done),
    .o_id     (w_id)
  );

  // State register.
  always_ff @(posedge uclock or negedge reset) begin
    if (!reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic. The top level parks in StTxDst while the serializer
  // walks the remaining TX states, and resumes when it reports the last byte.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:  if (req_put_i != r_get) w_state_nxt = StTxDst;
      StTxDst: if (w_tx_done) w_state_nxt = StRxSz;
      StRxSz:  if (w_rx_fire) w_state_nxt = StRxCmd;
      StRxCmd: if (w_rx_fire) w_state_nxt = StRxId;
      StRxId:  if (w_rx_fire) w_state_nxt = (r_rsp_sz == 8'd0) ? StDone : StRxDat;
      StRxDat: if (w_rx_fire && (r_rx_idx == r_rsp_sz - 8'd1)) w_state_nxt = StDone;
      StDone:  w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  // Outputs decoded from state.
  always_comb begin
    w_start   = 1'b0;
    rxi_ready = 1'b0;
    unique case (r_state)
      StIdle:                             w_start   = (req_put_i != r_get);
      StRxSz, StRxCmd, StRxId, StRxDat:   rxi_ready = 1'b1;
      default: ;
    endcase
  end

  // Response capture and completion toggle.
  always_ff @(posedge uclock or negedge reset) begin
    if (!reset) begin
      r_get     <= 1'b0;
      r_rsp_dat <= '0;
      r_rsp_sz  <= 8'h00;
      r_rsp_err <= 1'b0;
      r_rx_idx  <= 8'h00;
    end else begin
      unique case (r_state)
        StTxDst: begin
          if (w_tx_done) begin
            r_rsp_dat <= '0;
          end
        end
        StRxSz: begin
          if (w_rx_fire) begin
            // SZ=0 is read as SZ=1: no data bytes.
            r_rsp_sz <= (rxi_dat == 8'd0) ? 8'd0 : rxi_dat - 8'd1;
            r_rx_idx <= 8'h00;
          end
        end
        StRxCmd: begin
          if (w_rx_fire) begin
            r_rsp_err <= (rxi_dat != RspCmd);
          end
        end
        StRxId: begin
          if (w_rx_fire) begin
            r_rsp_err <= r_rsp_err | (rxi_dat != w_id_sent);
          end
        end
        StRxDat: begin
          if (w_rx_fire) begin
            // Bytes beyond the response buffer are drained without storing.
            for (int k = 0; k < int'(RSP_SZ) && k < 256; k++) begin
              if (r_rx_idx == 8'(k)) begin
                r_rsp_dat[8*k +: 8] <= rxi_dat;
              end
            end
            r_rx_idx <= r_rx_idx + 8'd1;
          end
        end
        StDone: begin
          r_get <= ~r_get;
        end
        default: ;
      endcase
    end
  end

endmodule
